id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Next-generation decode stage of the 5-stage MIPS pipeline. It holds the bypassed register file, a load-use hazard unit (FSM plus counter) and the ID/EX pipeline register.
- Sits between IF/ID and EX. It drives o_stall back to fetch and presents registered operands and control to EX.
- Generalises the previous decode stage with a configurable stall depth, flush and bubble insertion, and a write-through register file.

Parameters:
- NB, 32, datapath width.
- REGS, 5, register address width; the file holds 2**REGS entries.
- CTRL_W, 12, packed control-word width; bit layout defined in id_pkg.
- NB_SIZE_TYPE, 3, memory word-size field width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard; range 1..7.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_step  in  1  advance enable; all state, including register-file writes, updates only when high.
- i_flush  in  1  squash the instruction currently in ID (taken jump/branch).
- i_instruction  in  NB  IF/ID instruction.
- i_pc4  in  NB  PC+4 of the instruction.
- i_ctrl  in  CTRL_W  packed control word from control_unit.
- i_reg_dir  in  REGS  destination register from control_unit.
- i_ext_imm  in  NB  extended immediate.
- i_wb_reg_write  in  1  WB write enable.
- i_wb_reg_dir  in  REGS  WB address.
- i_wb_reg_write_data  in  NB  WB data.
- i_mips_register_number  in  REGS  debug read address.
- o_mips_register_data  out  NB  debug read data (bypassed).
- o_stall  out  1  hold PC and IF/ID.
- o_valid  out  1  ID/EX holds a real instruction.
- o_ctrl  out  CTRL_W  registered control word.
- o_reg_dir_to_write  out  REGS  registered destination register.
- o_data_a, o_data_b  out  NB  registered rs/rt data.
- o_extension_result  out  NB  registered immediate.
- o_shamt  out  NB  registered, zero-extended instruction[10:6].
- o_rs, o_rt  out  REGS  registered source addresses, for forwarding.
- o_funct  out  6  registered instruction[5:0].
- o_pc4  out  NB  registered PC+4.
- o_branch_taken  out  1  see Optional Feature.
- o_branch_target  out  NB  see Optional Feature.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - all registered outputs are 0 and o_valid=0;
  - all register-file entries are 0;
  - FSM goes to RUN with the counter at 0.
- Register file:
  - register 0 reads 0 and ignores writes;
  - writes occur at posedge when i_wb_reg_write, i_step and dir!=0 are all true;
  - reads are combinational; if the read address equals a nonzero WB address being written this cycle, the read returns i_wb_reg_write_data (write-through). This applies to the debug port as well.
- Hazard detect (combinational): hit = o_valid & o_ctrl[MEM_READ] & (o_reg_dir_to_write != 0) & (o_reg_dir_to_write == rs | o_reg_dir_to_write == rt). rs is instruction[25:21], rt is instruction[20:16]; rt is compared conservatively, always.
- FSM states RUN and STALL; the 3-bit counter cnt holds the bubbles remaining.
  - RUN: o_stall = hit & !i_flush.
  - RUN, on i_step with hit: insert a bubble. If STALL_CYCLES>1, set cnt=STALL_CYCLES-1 and go to STALL; otherwise stay in RUN.
  - RUN, on i_step without hit: load the ID/EX register.
  - STALL: o_stall=1. Each i_step inserts a bubble and decrements cnt; at cnt==1 it goes to RUN.
  - i_flush in either state: bubble, go to RUN, cnt=0, o_stall=0.
- ID/EX update priority at posedge with i_step: reset > flush > bubble > load.
  - Bubble: o_valid=0; o_ctrl, o_reg_dir_to_write and all data fields are 0.
  - Load: o_valid=1, and all fields are captured from the current instruction.
- Latency: an operand is visible at the ID/EX outputs one i_step edge after the instruction is present in ID.
- i_step=0: no state changes; o_stall still reflects the current combinational value.

Optional Feature:
- Macro: ID_BRANCH_RESOLVE_EN.
- Defined:
  - o_branch_taken = !o_stall & i_ctrl[BRANCH] & (opcode 000100 ? a==b : opcode 000101 ? a!=b : 0), using the bypassed read data;
  - o_branch_target = i_pc4 + (i_ext_imm << 2);
  - the BRANCH bit is cleared when loaded into o_ctrl;
  - hit additionally covers: i_ctrl[BRANCH] & o_valid & o_ctrl[REG_WRITE] & a dest match on rs/rt. This case inserts a single bubble.
- Undefined: o_branch_taken=0 and o_branch_target=0. The BRANCH bit passes through to o_ctrl unchanged.

Decomposition:
- id_pkg holds:
  - CTRL_W;
  - control bit indices ALU_SRC, MEM_READ, MEM_WRITE, MEM_TO_REG, REG_WRITE, BRANCH, JUMP, SIGNED, EXT_MODE[1:0], WORD_SIZE[2:0];
  - opcode constants OP_BEQ and OP_BNE;
  - the FSM state encoding.
- Sub-module id_regfile: 2 read ports, 1 debug read port, 1 write port, write-through bypass.

Test Plan:
- Reset mid-stream with i_reset=0 while o_valid=1 -> all outputs 0 immediately (asynchronous); after release, a read of r5 returns 0.
- WB writes r7=0x12345678 while ID decodes an instruction with rs=7 -> o_data_a=0x12345678 on the next edge; a write to r0 leaves r0 reading 0.
- lw r3 followed by add r4,r3,r2 with STALL_CYCLES=1 -> o_stall high for 1 cycle, one bubble (o_valid=0, o_ctrl=0), then the add loads.
- Same sequence with STALL_CYCLES=3 -> o_stall high for 3 steps, 3 consecutive bubbles; i_step=0 in the middle holds the counter.
- i_flush asserted during STALL -> bubble, o_stall=0 next cycle, FSM in RUN.
- With ID_BRANCH_RESOLVE_EN: beq with r1=r2=5, pc4=0x100, imm=4 -> o_branch_taken=1 and o_branch_target=0x110; with r2=6 -> o_branch_taken=0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode-stage definitions: control-word layout, branch opcodes, hazard FSM states.
// The load sign flag lives in the top bit of the word-size field.
package id_pkg;

  localparam int CTRL_W = 12;

  localparam int ALU_SRC      = 0;
  localparam int MEM_READ     = 1;
  localparam int MEM_WRITE    = 2;
  localparam int MEM_TO_REG   = 3;
  localparam int REG_WRITE    = 4;
  localparam int BRANCH       = 5;
  localparam int JUMP         = 6;
  localparam int EXT_MODE_LO  = 7;
  localparam int EXT_MODE_HI  = 8;
  localparam int WORD_SIZE_LO = 9;
  localparam int WORD_SIZE_HI = 11;
  localparam int SIGNED       = 11;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/id_regfile.sv
// Register file with two operand ports, a debug port and a single write port.
// Reads of the register being written this step return the incoming data.
module id_regfile #(
  parameter int NB   = 32,
  parameter int REGS = 5
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_step,
  input  logic            i_we,
  input  logic [REGS-1:0] i_wdir,
  input  logic [NB-1:0]   i_wdata,
  input  logic [REGS-1:0] i_ra,
  input  logic [REGS-1:0] i_rb,
  input  logic [REGS-1:0] i_rd,
  output logic [NB-1:0]   o_a,
  output logic [NB-1:0]   o_b,
  output logic [NB-1:0]   o_d
);

  logic [NB-1:0] regs [2**REGS];
  logic          wr;

  assign wr = i_we & i_step & (i_wdir != '0);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 2**REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr) begin
      regs[i_wdir] <= i_wdata;
    end
  end

  assign o_a = (i_ra == '0) ? '0 :
               (wr && i_wdir == i_ra) ? i_wdata : regs[i_ra];
  assign o_b = (i_rb == '0) ? '0 :
               (wr && i_wdir == i_rb) ? i_wdata : regs[i_rb];
  assign o_d = (i_rd == '0) ? '0 :
               (wr && i_wdir == i_rd) ? i_wdata : regs[i_rd];

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage: bypassed register file, load-use hazard FSM, ID/EX register.
// ID_BRANCH_RESOLVE_EN resolves beq/bne in ID and extends hazard detection.
module id_ex_stage
  import id_pkg::*;
#(
  parameter int NB           = 32,
  parameter int REGS         = 5,
  parameter int CTRL_W       = id_pkg::CTRL_W,
  parameter int NB_SIZE_TYPE = 3,
  parameter int STALL_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic [NB-1:0]     i_instruction,
  input  logic [NB-1:0]     i_pc4,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [REGS-1:0]   i_reg_dir,
  input  logic [NB-1:0]     i_ext_imm,
  input  logic              i_wb_reg_write,
  input  logic [REGS-1:0]   i_wb_reg_dir,
  input  logic [NB-1:0]     i_wb_reg_write_data,
  input  logic [REGS-1:0]   i_mips_register_number,
  output logic [NB-1:0]     o_mips_register_data,
  output logic              o_stall,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [REGS-1:0]   o_reg_dir_to_write,
  output logic [NB-1:0]     o_data_a,
  output logic [NB-1:0]     o_data_b,
  output logic [NB-1:0]     o_extension_result,
  output logic [NB-1:0]     o_shamt,
  output logic [REGS-1:0]   o_rs,
  output logic [REGS-1:0]   o_rt,
  output logic [5:0]        o_funct,
  output logic [NB-1:0]     o_pc4,
  output logic              o_branch_taken,
  output logic [NB-1:0]     o_branch_target
);

  if (STALL_CYCLES < 1 || STALL_CYCLES > 7) begin : g_bad_stall
    $error("STALL_CYCLES must be in 1..7");
  end
  if (WORD_SIZE_HI - WORD_SIZE_LO + 1 != NB_SIZE_TYPE
      || CTRL_W != id_pkg::CTRL_W) begin : g_bad_ctrl
    $error("control word layout mismatch");
  end

  logic [REGS-1:0]   rs, rt;
  logic [NB-1:0]     rd_a, rd_b;
  logic              dst_match, hit_lu, hit_br, hit;
  logic              bubble;
  logic [CTRL_W-1:0] ld_ctrl;
  hz_state_e         state, nxt_state;
  logic [2:0]        cnt, nxt_cnt;
  logic              unused_ok;

  assign rs = i_instruction[25:21];
  assign rt = i_instruction[20:16];
  assign unused_ok = ^{i_instruction[31:26], i_instruction[15:11]};

  id_regfile #(
    .NB   (NB),
    .REGS (REGS)
  ) u_regfile (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_step  (i_step),
    .i_we    (i_wb_reg_write),
    .i_wdir  (i_wb_reg_dir),
    .i_wdata (i_wb_reg_write_data),
    .i_ra    (rs),
    .i_rb    (rt),
    .i_rd    (i_mips_register_number),
    .o_a     (rd_a),
    .o_b     (rd_b),
    .o_d     (o_mips_register_data)
  );

  assign dst_match = (o_reg_dir_to_write != '0)
                   & ((o_reg_dir_to_write == rs)
                   |  (o_reg_dir_to_write == rt));
  assign hit_lu = o_valid & o_ctrl[MEM_READ] & dst_match;

`ifdef ID_BRANCH_RESOLVE_EN
  logic br_cond;

  // A branch compares in ID, so any in-flight producer must drain first.
  assign hit_br = i_ctrl[BRANCH] & o_valid
                & o_ctrl[REG_WRITE] & dst_match;

  always_comb begin
    br_cond = 1'b0;
    case (i_instruction[31:26])
      OP_BEQ:  br_cond = (rd_a == rd_b);
      OP_BNE:  br_cond = (rd_a != rd_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign o_branch_taken  = ~o_stall & i_ctrl[BRANCH] & br_cond;
  assign o_branch_target = i_pc4 + (i_ext_imm << 2);

  always_comb begin
    ld_ctrl         = i_ctrl;
    ld_ctrl[BRANCH] = 1'b0;
  end
`else
  assign hit_br          = 1'b0;
  assign o_branch_taken  = 1'b0;
  assign o_branch_target = '0;
  assign ld_ctrl         = i_ctrl;
`endif

  assign hit = hit_lu | hit_br;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (i_step) begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    o_stall   = 1'b0;
    bubble    = 1'b0;
    unique case (state)
      RUN: begin
        o_stall = hit & ~i_flush;
        if (i_flush) begin
          bubble  = 1'b1;
          nxt_cnt = '0;
        end else if (hit) begin
          bubble = 1'b1;
          if (hit_lu && STALL_CYCLES > 1) begin
            nxt_cnt   = 3'(STALL_CYCLES - 1);
            nxt_state = STALL;
          end
        end
      end
      STALL: begin
        o_stall = ~i_flush;
        bubble  = 1'b1;
        if (i_flush || cnt == 3'd1) begin
          nxt_state = RUN;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt - 3'd1;
        end
      end
      default: begin
        nxt_state = RUN;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_valid            <= 1'b0;
      o_ctrl             <= '0;
      o_reg_dir_to_write <= '0;
      o_data_a           <= '0;
      o_data_b           <= '0;
      o_extension_result <= '0;
      o_shamt            <= '0;
      o_rs               <= '0;
      o_rt               <= '0;
      o_funct            <= '0;
      o_pc4              <= '0;
    end else if (i_step) begin
      if (bubble) begin
        o_valid            <= 1'b0;
        o_ctrl             <= '0;
        o_reg_dir_to_write <= '0;
        o_data_a           <= '0;
        o_data_b           <= '0;
        o_extension_result <= '0;
        o_shamt            <= '0;
        o_rs               <= '0;
        o_rt               <= '0;
        o_funct            <= '0;
        o_pc4              <= '0;
      end else begin
        o_valid            <= 1'b1;
        o_ctrl             <= ld_ctrl;
        o_reg_dir_to_write <= i_reg_dir;
        o_data_a           <= rd_a;
        o_data_b           <= rd_b;
        o_extension_result <= i_ext_imm;
        o_shamt            <= {{(NB-5){1'b0}}, i_instruction[10:6]};
        o_rs               <= rs;
        o_rt               <= rt;
        o_funct            <= i_instruction[5:0];
        o_pc4              <= i_pc4;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: two instances (1 and 3 stall cycles) against a
// behavioural model, plus directed literal checks.
module tb_id_ex_stage;

  localparam logic [11:0] C_LW  = 12'h01B;
  localparam logic [11:0] C_ADD = 12'h010;
  localparam logic [11:0] C_BR  = 12'h020;

`ifdef ID_BRANCH_RESOLVE_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, step, flush;
  logic [31:0] instr, pc4, imm, wb_data;
  logic [11:0] ctrl;
  logic [4:0]  rdir, wb_dir, dbg;
  logic        wb_we;

  logic        stall [2], valid [2], taken [2];
  logic [11:0] octrl [2];
  logic [4:0]  odest [2], ors [2], ort [2];
  logic [5:0]  ofunct [2];
  logic [31:0] oa [2], ob [2], oimm [2], oshamt [2], opc4 [2];
  logic [31:0] otgt [2], odbg [2];

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;

  always #5 clk = ~clk;

  id_ex_stage #(.STALL_CYCLES(1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_step(step), .i_flush(flush),
    .i_instruction(instr), .i_pc4(pc4), .i_ctrl(ctrl),
    .i_reg_dir(rdir), .i_ext_imm(imm),
    .i_wb_reg_write(wb_we), .i_wb_reg_dir(wb_dir),
    .i_wb_reg_write_data(wb_data),
    .i_mips_register_number(dbg), .o_mips_register_data(odbg[0]),
    .o_stall(stall[0]), .o_valid(valid[0]), .o_ctrl(octrl[0]),
    .o_reg_dir_to_write(odest[0]), .o_data_a(oa[0]), .o_data_b(ob[0]),
    .o_extension_result(oimm[0]), .o_shamt(oshamt[0]),
    .o_rs(ors[0]), .o_rt(ort[0]), .o_funct(ofunct[0]), .o_pc4(opc4[0]),
    .o_branch_taken(taken[0]), .o_branch_target(otgt[0])
  );

  id_ex_stage #(.STALL_CYCLES(3)) u3 (
    .i_clk(clk), .i_reset(rst), .i_step(step), .i_flush(flush),
    .i_instruction(instr), .i_pc4(pc4), .i_ctrl(ctrl),
    .i_reg_dir(rdir), .i_ext_imm(imm),
    .i_wb_reg_write(wb_we), .i_wb_reg_dir(wb_dir),
    .i_wb_reg_write_data(wb_data),
    .i_mips_register_number(dbg), .o_mips_register_data(odbg[1]),
    .o_stall(stall[1]), .o_valid(valid[1]), .o_ctrl(octrl[1]),
    .o_reg_dir_to_write(odest[1]), .o_data_a(oa[1]), .o_data_b(ob[1]),
    .o_extension_result(oimm[1]), .o_shamt(oshamt[1]),
    .o_rs(ors[1]), .o_rt(ort[1]), .o_funct(ofunct[1]), .o_pc4(opc4[1]),
    .o_branch_taken(taken[1]), .o_branch_target(otgt[1])
  );

  // Model: ID/EX contents and remaining bubbles per instance.
  int          depth [2] = '{1, 3};
  int          m_rem [2];
  logic        m_valid [2];
  logic [11:0] m_ctrl [2];
  logic [4:0]  m_dest [2], m_rs [2], m_rt [2];
  logic [5:0]  m_funct [2];
  logic [31:0] m_a [2], m_b [2], m_imm [2], m_shamt [2], m_pc4 [2];
  logic [31:0] m_rf [32];

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && step && wb_dir == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit dmatch(input int k);
    return m_dest[k] != 5'd0 &&
           (m_dest[k] == instr[25:21] || m_dest[k] == instr[20:16]);
  endfunction

  function automatic bit hz_lu(input int k);
    return m_valid[k] && m_ctrl[k][1] && dmatch(k);
  endfunction

  function automatic bit hz_br(input int k);
    return BR_EN && ctrl[5] && m_valid[k] && m_ctrl[k][4] && dmatch(k);
  endfunction

  function automatic bit e_stall(input int k);
    return !flush && (m_rem[k] > 0 || hz_lu(k) || hz_br(k));
  endfunction

  function automatic bit e_taken(input int k);
    logic [31:0] a, b;
    a = rf_rd(instr[25:21]);
    b = rf_rd(instr[20:16]);
    if (!BR_EN || e_stall(k) || !ctrl[5]) return 1'b0;
    if (instr[31:26] == 6'd4) return a == b;
    if (instr[31:26] == 6'd5) return a != b;
    return 1'b0;
  endfunction

  task automatic clr(input int k);
    m_valid[k] = 0; m_ctrl[k] = 0; m_dest[k] = 0; m_rs[k] = 0;
    m_rt[k] = 0; m_funct[k] = 0; m_a[k] = 0; m_b[k] = 0;
    m_imm[k] = 0; m_shamt[k] = 0; m_pc4[k] = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        clr(k);
        m_rem[k] = 0;
      end
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else if (step) begin
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          clr(k); m_rem[k] = 0;
        end else if (m_rem[k] > 0) begin
          clr(k); m_rem[k] = m_rem[k] - 1;
        end else if (hz_lu(k)) begin
          clr(k); m_rem[k] = depth[k] - 1;
        end else if (hz_br(k)) begin
          clr(k);
        end else begin
          m_valid[k] = 1;
          m_ctrl[k]  = BR_EN ? (ctrl & ~C_BR) : ctrl;
          m_dest[k]  = rdir;
          m_a[k]     = rf_rd(instr[25:21]);
          m_b[k]     = rf_rd(instr[20:16]);
          m_imm[k]   = imm;
          m_shamt[k] = {27'd0, instr[10:6]};
          m_rs[k]    = instr[25:21];
          m_rt[k]    = instr[20:16];
          m_funct[k] = instr[5:0];
          m_pc4[k]   = pc4;
        end
      end
      if (wb_we && wb_dir != 5'd0) m_rf[wb_dir] = wb_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("i%0d valid", k), 32'(valid[k]), 32'(m_valid[k]));
        chk($sformatf("i%0d ctrl", k), 32'(octrl[k]), 32'(m_ctrl[k]));
        chk($sformatf("i%0d dest", k), 32'(odest[k]), 32'(m_dest[k]));
        chk($sformatf("i%0d data_a", k), oa[k], m_a[k]);
        chk($sformatf("i%0d data_b", k), ob[k], m_b[k]);
        chk($sformatf("i%0d imm", k), oimm[k], m_imm[k]);
        chk($sformatf("i%0d shamt", k), oshamt[k], m_shamt[k]);
        chk($sformatf("i%0d rs", k), 32'(ors[k]), 32'(m_rs[k]));
        chk($sformatf("i%0d rt", k), 32'(ort[k]), 32'(m_rt[k]));
        chk($sformatf("i%0d funct", k), 32'(ofunct[k]), 32'(m_funct[k]));
        chk($sformatf("i%0d pc4", k), opc4[k], m_pc4[k]);
        chk($sformatf("i%0d stall", k), 32'(stall[k]), 32'(e_stall(k)));
        chk($sformatf("i%0d dbg", k), odbg[k], rf_rd(dbg));
        chk($sformatf("i%0d taken", k), 32'(taken[k]), 32'(e_taken(k)));
        chk($sformatf("i%0d target", k), otgt[k],
            BR_EN ? pc4 + (imm << 2) : 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic [15:0] low,
                        input logic [11:0] c, input logic [4:0] d);
    instr = {op, s, t, low};
    imm   = {{16{low[15]}}, low};
    ctrl  = c;
    rdir  = d;
  endtask

  task automatic wb(input logic [4:0] d, input logic [31:0] v);
    wb_we = 1'b1; wb_dir = d; wb_data = v;
  endtask

  initial begin
    rst = 0; step = 1; flush = 0; instr = 0; pc4 = 32'h40; ctrl = 0;
    rdir = 0; imm = 0; wb_we = 0; wb_dir = 0; wb_data = 0; dbg = 0;
    run_chk = 1'b1;
    repeat (2) tick();
    chk("reset valid", 32'(valid[0]), 32'd0);
    chk("reset stall", 32'(stall[1]), 32'd0);
    chk("reset data_a", oa[1], 32'd0);
    rst = 1;

    // add r8,r7,r0 decoded while WB writes r7
    set_id(6'd0, 5'd7, 5'd0, 16'h4020, C_ADD, 5'd8);
    wb(5'd7, 32'h12345678);
    tick();
    wb_we = 0;
    chk("wt data_a", oa[0], 32'h12345678);
    chk("wt valid", 32'(valid[1]), 32'd1);
    chk("wt shamt", oshamt[0], 32'd0);
    chk("wt funct", 32'(ofunct[0]), 32'h20);

    wb(5'd0, 32'hdeadbeef);
    #1 chk("r0 bypass", odbg[0], 32'd0);
    tick();
    chk("r0 read", odbg[1], 32'd0);
    wb(5'd2, 32'h22); tick();
    wb(5'd5, 32'h55); tick();
    wb_we = 0;
    dbg = 5'd5;
    #1 chk("dbg r5", odbg[0], 32'h55);

    // lw r3,0(r1) then add r4,r3,r2
    set_id(6'd35, 5'd1, 5'd3, 16'h0000, C_LW, 5'd3);
    tick();
    set_id(6'd0, 5'd3, 5'd2, 16'h2020, C_ADD, 5'd4);
    #1 chk("lu stall s1", 32'(stall[0]), 32'd1);
    chk("lu stall s3", 32'(stall[1]), 32'd1);
    tick();
    chk("bubble valid", 32'(valid[0]), 32'd0);
    chk("bubble ctrl", 32'(octrl[0]), 32'd0);
    chk("s1 released", 32'(stall[0]), 32'd0);
    chk("s3 held", 32'(stall[1]), 32'd1);
    step = 0;
    tick();
    chk("hold stall", 32'(stall[1]), 32'd1);
    chk("hold valid", 32'(valid[1]), 32'd0);
    step = 1;
    tick();
    chk("s1 add loaded", 32'(octrl[0]), 32'(C_ADD));
    chk("s1 add data_b", ob[0], 32'h22);
    chk("s3 bubble 2", 32'(stall[1]), 32'd1);
    tick();
    chk("s3 released", 32'(stall[1]), 32'd0);
    chk("s3 bubble 3", 32'(valid[1]), 32'd0);
    tick();
    chk("s3 add valid", 32'(valid[1]), 32'd1);
    chk("s3 add data_b", ob[1], 32'h22);

    // flush while in STALL
    set_id(6'd35, 5'd1, 5'd3, 16'h0000, C_LW, 5'd3);
    tick();
    set_id(6'd0, 5'd3, 5'd2, 16'h2020, C_ADD, 5'd4);
    tick();
    flush = 1;
    #1 chk("flush stall", 32'(stall[1]), 32'd0);
    tick();
    flush = 0;
    #1 chk("after flush", 32'(stall[1]), 32'd0);
    chk("flush bubble", 32'(valid[1]), 32'd0);
    tick();
    chk("post flush load", 32'(valid[1]), 32'd1);

    // asynchronous reset with a valid instruction in ID/EX
    #1 rst = 0;
    #1 chk("async valid", 32'(valid[0]), 32'd0);
    chk("async data_b", ob[1], 32'd0);
    chk("async ctrl", 32'(octrl[1]), 32'd0);
    @(negedge clk);
    #1 rst = 1;
    dbg = 5'd5;
    #1 chk("r5 after reset", odbg[0], 32'd0);

    // branch resolution
    set_id(6'd0, 5'd0, 5'd0, 16'h0000, 12'h000, 5'd0);
    wb(5'd1, 32'd5); tick();
    wb(5'd2, 32'd5); tick();
    wb_we = 0;
    pc4 = 32'h100;
    set_id(6'd4, 5'd1, 5'd2, 16'h0004, C_BR, 5'd0);
    #1 chk("beq taken", 32'(taken[0]), 32'(BR_EN));
    chk("beq target", otgt[1], BR_EN ? 32'h110 : 32'd0);
    wb(5'd2, 32'd6);
    #1 chk("beq bypass ne", 32'(taken[1]), 32'd0);
    tick();
    wb_we = 0;
    #1 chk("beq ne", 32'(taken[0]), 32'd0);
    chk("br ctrl", 32'(octrl[0]), BR_EN ? 32'd0 : 32'(C_BR));
    repeat (2) tick();

    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
